// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_pkg
// Purpose  : Shared defaults and helpers for the register write arbiter.
// Revision : 1.0  initial release
// ============================================================================
package reg_write_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NREQ  = 4;

  // Number of bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_we.sv
`default_nettype none
// ============================================================================
// Module   : register_we
// Purpose  : Enable-gated storage register with asynchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module register_we #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load new data only when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en) data_d = in;
  end

  // Storage flop, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign out = data_q;

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Round-robin arbiter granting one client per cycle write access
//            to a shared register; returns a registered one-hot acknowledge.
// Revision : 1.0  initial release
// ============================================================================
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        owner,
  output logic                  wr_valid,
  output logic                  busy
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_W = IDW'(NREQ - 1);

  generate
    if (IDW != clog2_min1(NREQ)) begin : g_idw_check
      $error("reg_write_arbiter: IDW does not match NREQ");
    end
  endgenerate

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic             wr_valid_q, wr_valid_d;

  logic [NREQ-1:0]  eligible;
  logic             any_eligible;
  logic [IDW-1:0]   winner;
  logic [IDW:0]     scan_idx;
  logic [WIDTH-1:0] win_data;

  // A client still seeing its acknowledge is masked so it cannot write twice in a row.
  assign eligible = req & ~gnt_q;
  assign busy     = |eligible;

  // Scan from ptr upward with wrap; walking offsets high-to-low leaves the
  // nearest eligible client (smallest offset) as the winner.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    scan_idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
      if (eligible[scan_idx[IDW-1:0]]) begin
        winner       = scan_idx[IDW-1:0];
        any_eligible = 1'b1;
      end
    end
  end

  // Select the winning client's data lane.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) win_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Next grant, owner, pointer and valid state.
  always_comb begin
    gnt_d      = '0;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    wr_valid_d = any_eligible;
    for (int i = 0; i < NREQ; i++) begin
      gnt_d[i] = any_eligible && (winner == IDW'(i));
    end
    if (any_eligible) begin
      owner_d = winner;
      ptr_d   = (winner == LAST_W) ? '0 : winner + IDW'(1);
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q      <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  register_we #(
    .WIDTH (WIDTH)
  ) u_storage (
    .clk   (clk),
    .reset (reset),
    .en    (any_eligible),
    .in    (win_data),
    .out   (q)
  );

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign wr_valid = wr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Scoreboard bench for reg_write_arbiter (WIDTH=8, NREQ=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        wr_valid;
  logic        busy;

  reg_write_arbiter #(.WIDTH(8), .NREQ(4), .IDW(2)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .q        (q),
    .owner    (owner),
    .wr_valid (wr_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] q;
    logic [1:0] owner;
    logic       wv;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference state of the arbiter
  logic [3:0] m_gnt;
  logic [7:0] m_q;
  logic [1:0] m_owner;
  int         m_ptr;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt = 4'b0; m_q = 8'h00; m_owner = 2'd0; m_ptr = 0;
  endtask

  // One arbitration cycle: predict at negedge, compare after the next posedge.
  task automatic step(input string tag);
    logic [3:0] elig;
    int   w;
    bit   f;
    exp_t e;
    @(negedge clk);
    elig = req & ~m_gnt;
    chk_eq({tag, "_busy"}, {31'b0, busy}, {31'b0, |elig});
    f = 1'b0; w = 0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (!f && elig[i]) begin f = 1'b1; w = i; end
    end
    if (f) begin
      m_q     = wdata[w*8 +: 8];
      m_gnt   = 4'b0001 << w;
      m_owner = 2'(w);
      m_ptr   = (w + 1) % 4;
    end else begin
      m_gnt = 4'b0;
    end
    e.gnt = m_gnt; e.q = m_q; e.owner = m_owner; e.wv = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk_eq({tag, "_gnt"},   {28'b0, gnt},      {28'b0, e.gnt});
      chk_eq({tag, "_q"},     {24'b0, q},        {24'b0, e.q});
      chk_eq({tag, "_owner"}, {30'b0, owner},    {30'b0, e.owner});
      chk_eq({tag, "_wv"},    {31'b0, wr_valid}, {31'b0, e.wv});
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk_eq({tag, "_q"},     {24'b0, q},        32'h0);
    chk_eq({tag, "_gnt"},   {28'b0, gnt},      32'h0);
    chk_eq({tag, "_owner"}, {30'b0, owner},    32'h0);
    chk_eq({tag, "_wv"},    {31'b0, wr_valid}, 32'h0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] prev_gnt;
  logic [3:0] exp4 [4];

  initial begin
    reset = 1'b1; req = 4'b0; wdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("por");
    #1 reset = 1'b0;

    // Reset asserted mid-cycle while everyone requests
    req = 4'b1111; wdata = {8'h43, 8'h32, 8'h21, 8'h10};
    step("pre_rst");
    #2 reset = 1'b1;
    #1 chk_cleared("rst_async");
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      chk_cleared("rst_hold");
    end
    #1 reset = 1'b0;

    // All clients request, each drops after its acknowledge
    exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      step("all");
      chk_eq("all_gnt_seq", {28'b0, gnt}, {28'b0, exp4[i]});
      req = req & ~gnt;
    end
    chk_eq("all_last_q", {24'b0, q}, 32'h43);
    step("all_idle");

    // Single client
    req = 4'b0010; wdata = {8'hFF, 8'hFF, 8'hA5, 8'hFF};
    step("single");
    chk_eq("single_q", {24'b0, q}, 32'hA5);
    chk_eq("single_gnt", {28'b0, gnt}, 32'b0010);
    chk_eq("single_owner", {30'b0, owner}, 32'd1);
    req = 4'b0;
    step("single_drop");
    chk_eq("single_hold_q", {24'b0, q}, 32'hA5);

    // Idle: nothing changes, then wrap-around scan from ptr=2
    repeat (5) step("idle");
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0011;
    step("wrap");
    chk_eq("wrap_gnt", {28'b0, gnt}, 32'b0001);
    chk_eq("wrap_q", {24'b0, q}, 32'h11);
    req = 4'b0010;
    step("wrap2");
    req = 4'b0;
    step("wrap_idle");

    // Persistent requesters 0 and 2, pointer starts at 2
    req = 4'b0101;
    exp4 = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    prev_gnt = 4'b0;
    for (int i = 0; i < 4; i++) begin
      step("persist");
      chk_eq("persist_seq", {28'b0, gnt}, {28'b0, exp4[i]});
      chk_eq("persist_no_repeat", {28'b0, gnt & prev_gnt}, 32'b0);
      prev_gnt = gnt;
    end

    // Reset pulse mid-operation; first grant afterwards goes to client 0
    #2 reset = 1'b1;
    #1 chk_cleared("midrst");
    model_reset();
    @(posedge clk); #1;
    chk_cleared("midrst_hold");
    #1 reset = 1'b0;
    step("post_rst");
    chk_eq("post_rst_gnt", {28'b0, gnt}, 32'b0001);
    step("post_rst2");
    step("post_rst3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one enable-gated storage register among NREQ requesters.
- Each cycle it picks at most one requesting client and drives that client's data into the register with a one-cycle write enable.
- It returns a registered one-hot grant/acknowledge and reports which client wrote last.
- It sits between client FSMs and a shared configuration/data register in the basic-modules datapath.

Parameters:
- WIDTH, 8, data width of the shared register
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of the requester index; must equal ceil(log2(NREQ)), minimum 1

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-client write request, level-sensitive
- wdata  input  NREQ*WIDTH  flattened client data; client i uses bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot acknowledge; bit i high for the one cycle after client i's write
- q  output  WIDTH  current value of the shared register
- owner  output  IDW  index of the client that performed the most recent write
- wr_valid  output  1  high for the one cycle after any write (equals |gnt)
- busy  output  1  combinational; high when any eligible request exists this cycle

Behaviour:
- Reset values (asynchronous, immediate): q=0, gnt=0, owner=0, wr_valid=0, internal pointer ptr=0.
- Eligibility: client i is eligible in a cycle iff req[i]=1 and gnt[i]=0.
  - The gnt mask stops a client that is still holding req during its acknowledge cycle from writing twice back-to-back.
- Selection (combinational): winner is the first eligible index found scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (modulo NREQ).
- On the rising edge with at least one eligible client (winner w):
  - q <= wdata[w]
  - gnt <= one-hot(w)
  - owner <= w
  - wr_valid <= 1
  - ptr <= (w+1) mod NREQ; wrap from NREQ-1 to 0
- On the rising edge with no eligible client:
  - q, owner and ptr hold.
  - gnt <= 0, wr_valid <= 0.
- Latency and handshake:
  - Data is written at the first edge where the client wins; gnt is visible for the following cycle only.
  - The client must hold req and wdata stable until it sees gnt.
  - The client may drop req in the gnt cycle or keep it asserted to request again. When kept, it is eligible from the cycle after gnt.
- Throughput: at most one write per cycle; with ≥2 clients requesting continuously, one write every cycle.
- Fairness: no client waits more than NREQ-1 writes by others once it is eligible.
- busy = |(req & ~gnt).
- Reset mid-operation:
  - Pending requests are discarded and no write occurs while reset is high.
  - The first edge after reset deasserts arbitrates from ptr=0.
- Unused wdata lanes of non-winning clients have no effect.

Decomposition:
- Shared constants in the common defines file: default WIDTH and NREQ, and a clog2 helper function used to check IDW.
- One sub-module: instantiate the existing register_we (WIDTH-parameterised) as the storage element.
  - Drive it with clk, reset, en = any-eligible, and in = muxed winner data.
  - Its out drives q.
- Arbitration and pointer logic stay in this module as a rotate/priority-encode/rotate-back block.

Test Plan:
1. Reset: assert reset=1 mid-cycle with req=4'b1111 → q=8'h00, gnt=0, owner=0, wr_valid=0 immediately; no write for the duration of reset.
2. Single client: req=4'b0010, wdata lane1=8'hA5 (others 8'hFF) → next edge q=8'hA5, gnt=4'b0010, owner=1, wr_valid=1. Client drops req → following cycle gnt=0, q stays 8'hA5.
3. All request, each drops req after gnt: req=4'b1111, lanes 0..3 = 8'h10, 8'h21, 8'h32, 8'h43, ptr=0 → gnt sequence 0001, 0010, 0100, 1000 on consecutive cycles; q = 10, 21, 32, 43; ptr wraps to 0.
4. Persistent requesters: req=4'b0101 held high continuously → grants alternate 0001, 0100, 0001, 0100; no client is ever granted twice in a row; one write per cycle.
5. Idle: after scenario 2 (ptr=2), req=0 for 5 cycles → q, owner hold; gnt=0, busy=0. Then req=4'b0011 → client 0 wins first (scan from ptr=2 wraps to index 0).
6. Reset mid-operation: during scenario 4, pulse reset for 1 cycle → outputs clear; the first grant after release goes to client 0.
